// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: arbiter state encoding, default bus widths and frame geometry.
package fb_pkg;

  localparam int FB_ADDR_W   = 17;
  localparam int FB_DATA_W   = 8;
  localparam int FRAME_W     = 320;
  localparam int FRAME_H     = 240;
  localparam int FRAME_WORDS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_burst_ctr.sv
// Round-robin pointer and per-ownership beat counter for the framebuffer arbiter.
module rr_burst_ctr #(
  parameter int BURST_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_i,
  input  logic exit_i,
  input  logic owner_i,
  output logic ptr_o,
  output logic last_o
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;

  // An exit always hands the pointer to the writer that did not just own the RAM.
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (exit_i) begin
      cnt_d = '0;
      ptr_d = ~owner_i;
    end else if (beat_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (cnt_q == CNT_W'(BURST_MAX - 1));

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads pre-empt two bursting game-logic writers.
// Statistics outputs are built only when FB_ARB_STATS_EN is defined.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int BURST_MAX = 16
) (
  input  logic              clk_pix,
  input  logic              sim_rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_valid,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_wr_beats,
  output logic [15:0]       stat_preempts,
  output logic [15:0]       stat_maxwait
`endif
);

  arb_state_e state_q, state_d;
  logic       rr_ptr, burst_last;
  logic       scan_acc, beat, exit_own, owner;
  logic [1:0] gnt;
  logic       scan_valid_q;

  rr_burst_ctr #(.BURST_MAX(BURST_MAX)) u_ctr (
    .clk_i   (clk_pix),
    .rst_i   (sim_rst),
    .beat_i  (beat),
    .exit_i  (exit_own),
    .owner_i (owner),
    .ptr_o   (rr_ptr),
    .last_o  (burst_last)
  );

  // A scan cycle freezes the FSM and counter so the pre-empted writer resumes where it stopped.
  always_comb begin
    state_d  = state_q;
    gnt      = 2'b00;
    owner    = 1'b0;
    exit_own = 1'b0;
    scan_acc = scan_req & ~sim_rst;
    if (!sim_rst && !scan_req) begin
      unique case (state_q)
        IDLE: begin
          owner = (wr_req == 2'b11) ? rr_ptr : wr_req[1];
          gnt   = wr_req & (owner ? 2'b10 : 2'b01);
        end
        OWN0: gnt = {1'b0, wr_req[0]};
        OWN1: begin
          owner = 1'b1;
          gnt   = {wr_req[1], 1'b0};
        end
        default: ;
      endcase
      exit_own = (|gnt) ? burst_last : (state_q != IDLE);
      if (exit_own) begin
        state_d = IDLE;
      end else if (|gnt) begin
        state_d = owner ? OWN1 : OWN0;
      end
    end
  end

  assign beat = |gnt;

  always_comb begin
    mem_en    = scan_acc | beat;
    mem_we    = beat;
    mem_addr  = owner ? wr_addr1 : wr_addr0;
    mem_wdata = owner ? wr_data1 : wr_data0;
    if (scan_acc) begin
      mem_addr = scan_addr;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      state_q      <= IDLE;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_valid_q <= scan_acc;
    end
  end

  assign wr_gnt     = gnt;
  assign scan_valid = scan_valid_q;
  assign scan_rdata = mem_rdata;

`ifdef FB_ARB_STATS_EN
  logic [31:0] beats_q;
  logic [15:0] preempts_q, maxwait_q, wait0_q, wait1_q, wait_hi;
  logic        blocked, blocked_q;

  // A pre-emption is one contiguous run of scan cycles that holds off a requesting writer.
  assign blocked = scan_acc & (|wr_req);
  assign wait_hi = (wait0_q > wait1_q) ? wait0_q : wait1_q;

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      beats_q    <= '0;
      preempts_q <= '0;
      maxwait_q  <= '0;
      wait0_q    <= '0;
      wait1_q    <= '0;
      blocked_q  <= 1'b0;
    end else begin
      if (beat && beats_q != 32'hFFFF_FFFF) begin
        beats_q <= beats_q + 32'd1;
      end
      if (blocked && !blocked_q) begin
        preempts_q <= sat_inc16(preempts_q);
      end
      blocked_q <= blocked;
      wait0_q   <= (wr_req[0] && !gnt[0]) ? sat_inc16(wait0_q) : 16'd0;
      wait1_q   <= (wr_req[1] && !gnt[1]) ? sat_inc16(wait1_q) : 16'd0;
      if (wait_hi > maxwait_q) begin
        maxwait_q <= wait_hi;
      end
    end
  end

  assign stat_wr_beats = beats_q;
  assign stat_preempts = preempts_q;
  assign stat_maxwait  = maxwait_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: ownership-level reference model checked every cycle plus directed scenarios.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int BM = 16;

  logic          clk_pix = 1'b0;
  logic          sim_rst, scan_req, scan_valid, mem_en, mem_we;
  logic [AW-1:0] scan_addr, wr_addr0, wr_addr1, mem_addr;
  logic [DW-1:0] scan_rdata, wr_data0, wr_data1, mem_wdata, mem_rdata;
  logic [1:0]    wr_req, wr_gnt;
`ifdef FB_ARB_STATS_EN
  logic [31:0]   stat_wr_beats;
  logic [15:0]   stat_preempts, stat_maxwait;
`endif

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk_pix    (clk_pix),
    .sim_rst    (sim_rst),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_rdata (scan_rdata),
    .scan_valid (scan_valid),
    .wr_req     (wr_req),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_data0   (wr_data0),
    .wr_data1   (wr_data1),
    .wr_gnt     (wr_gnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_wr_beats (stat_wr_beats),
    .stat_preempts (stat_preempts),
    .stat_maxwait  (stat_maxwait)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  // Environment RAM, one-cycle read latency.
  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk_pix) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the RAM, how many beats so far, whose turn is next.
  int          m_own   = -1;
  int          m_beats = 0;
  bit          m_ptr   = 1'b0;
  bit          m_sv    = 1'b0;
  bit [DW-1:0] m_rd    = '0;
  bit [DW-1:0] shadow [0:(1<<AW)-1];

  function automatic int m_winner();
    if (sim_rst || scan_req) return -1;
    if (m_own >= 0) return wr_req[m_own] ? m_own : -1;
    if (wr_req == 2'b11) return int'(m_ptr);
    if (wr_req[0]) return 0;
    if (wr_req[1]) return 1;
    return -1;
  endfunction

  always @(negedge clk_pix) begin : compare
    int         w;
    logic [1:0] eg;
    w  = m_winner();
    eg = (w == 0) ? 2'b01 : ((w == 1) ? 2'b10 : 2'b00);
    chk("wr_gnt", 32'(wr_gnt), 32'(eg));
    chk("mem_en", 32'(mem_en), 32'((scan_req && !sim_rst) || w >= 0));
    chk("mem_we", 32'(mem_we), 32'(w >= 0));
    chk("gnt_onehot", 32'(wr_gnt == 2'b11), 32'd0);
    if (scan_req && !sim_rst) begin
      chk("mem_addr_scan", 32'(mem_addr), 32'(scan_addr));
    end else if (w >= 0) begin
      chk("mem_addr_wr", 32'(mem_addr), 32'((w == 0) ? wr_addr0 : wr_addr1));
      chk("mem_wdata", 32'(mem_wdata), 32'((w == 0) ? wr_data0 : wr_data1));
    end
    chk("scan_valid", 32'(scan_valid), 32'(m_sv));
    if (m_sv) chk("scan_rdata", 32'(scan_rdata), 32'(m_rd));
  end

  always @(posedge clk_pix) begin : model
    int w;
    w = m_winner();
    if (sim_rst) begin
      m_own = -1; m_beats = 0; m_ptr = 1'b0; m_sv = 1'b0;
    end else begin
      m_sv = scan_req;
      if (scan_req) begin
        m_rd = shadow[scan_addr];
      end else if (w >= 0) begin
        if (w == 0) shadow[wr_addr0] = wr_data0;
        else        shadow[wr_addr1] = wr_data1;
        m_beats++;
        if (m_beats == BM) begin
          m_ptr = (w == 0); m_own = -1; m_beats = 0;
        end else begin
          m_own = w;
        end
      end else if (m_own >= 0) begin
        m_ptr = (m_own == 0); m_own = -1; m_beats = 0;
      end
    end
  end

  typedef struct {
    int            ev;
    logic [1:0]    gnt;
    logic          we;
    logic          sv;
    logic [DW-1:0] rd;
    logic [AW-1:0] addr;
  } rec_t;

  rec_t hist[$];
  int   w_rem [2];
  int   seen  [2];

  // One clock: record the cycle, then advance each writer past any beat it transferred.
  task automatic step();
    rec_t r;
    bit   x0, x1;
    @(negedge clk_pix);
    x0 = wr_req[0] & wr_gnt[0];
    x1 = wr_req[1] & wr_gnt[1];
    r.ev = x0 ? 0 : (x1 ? 1 : -1);
    r.gnt = wr_gnt; r.we = mem_we; r.sv = scan_valid; r.rd = scan_rdata; r.addr = mem_addr;
    hist.push_back(r);
    @(posedge clk_pix);
    #1;
    if (x0) begin seen[0]++; w_rem[0]--; wr_addr0 = wr_addr0 + 1'b1; wr_data0 = wr_data0 + 8'd3; end
    if (x1) begin seen[1]++; w_rem[1]--; wr_addr1 = wr_addr1 + 1'b1; wr_data1 = wr_data1 + 8'd5; end
    wr_req = {w_rem[1] > 0, w_rem[0] > 0};
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while ((w_rem[0] > 0 || w_rem[1] > 0) && n < budget) begin step(); n++; end
    chk({name, "_timeout"}, 32'(w_rem[0] + w_rem[1]), 32'd0);
    repeat (2) step();
  endtask

  task automatic run_seen(input int who, input int target, input string name, input int budget);
    int n = 0;
    while (seen[who] < target && n < budget) begin step(); n++; end
    chk(name, 32'(seen[who]), 32'(target));
  endtask

  task automatic do_reset(input int n);
    w_rem[0] = 0; w_rem[1] = 0;
    sim_rst = 1'b1;
    repeat (n) step();
    sim_rst = 1'b0;
  endtask

  function automatic int ev_at(input int k);
    if (k >= 0 && k < hist.size()) return hist[k].ev;
    return -9;
  endfunction

  function automatic int first_ev(input int from, input int who);
    for (int k = from; k < hist.size(); k++)
      if ((who < 0 && hist[k].ev >= 0) || (who >= 0 && hist[k].ev == who)) return k;
    return -1;
  endfunction

  function automatic int count_ev(input int from, input int to, input int who);
    int c = 0;
    for (int k = from; k < to && k < hist.size(); k++)
      if (hist[k].ev == who) c++;
    return c;
  endfunction

  initial begin
    int nv, bad, f0, f1, pulses, guard;
    sim_rst = 1'b1; scan_req = 1'b0; scan_addr = '0; wr_req = 2'b00;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    w_rem = '{0, 0}; seen = '{0, 0};

    repeat (3) step();
    chk("rst_scan_valid", 32'(scan_valid), 32'd0);
    chk("rst_gnt", 32'(wr_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    sim_rst = 1'b0;

    // Scanout read held for four cycles over a word written just before.
    wr_addr0 = 17'h00100; wr_data0 = 8'h5A; w_rem[0] = 1;
    run_idle("scan_prefill", 20);
    scan_addr = 17'h00100; scan_req = 1'b1; hist.delete();
    repeat (4) step();
    scan_req = 1'b0;
    repeat (2) step();
    nv = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (hist[k].sv) nv++;
      if (k < 4 && (hist[k].gnt != 2'b00 || hist[k].we || hist[k].addr != 17'h00100)) bad++;
    end
    chk("scan_valid_count", 32'(nv), 32'd4);
    chk("scan_valid_cyc1", 32'(hist[0].sv), 32'd0);
    chk("scan_valid_cyc2", 32'(hist[1].sv), 32'd1);
    chk("scan_valid_cyc6", 32'(hist[5].sv), 32'd0);
    chk("scan_rdata_lit", 32'(hist[1].rd), 32'h5A);
    chk("scan_no_write", 32'(bad), 32'd0);

    // Both writers from IDLE with pointer 0.
    do_reset(1);
    wr_addr0 = 17'h01000; wr_addr1 = 17'h02000; seen = '{0, 0};
    w_rem = '{20, 20}; hist.delete();
    run_idle("burst", 200);
    f1 = first_ev(0, 1);
    chk("burst_first_owner", 32'(ev_at(first_ev(0, -1))), 32'd0);
    chk("burst_w0_len", 32'(count_ev(0, f1, 0)), 32'd16);
    chk("burst_handover", 32'(ev_at(f1 - 1)), 32'd0);
    chk("burst_totals", 32'(seen[0] + seen[1]), 32'd40);

    // Writer 1 pre-empted after its fifth beat.
    seen = '{0, 0}; w_rem[1] = 20;
    step();
    w_rem[0] = 4;
    run_seen(1, 5, "pre_w1_five", 50);
    scan_req = 1'b1; hist.delete();
    repeat (3) step();
    scan_req = 1'b0;
    run_idle("preempt", 200);
    chk("pre_gnt_zero", 32'(hist[0].gnt | hist[1].gnt | hist[2].gnt), 32'd0);
    chk("pre_resume_w1", 32'(ev_at(3)), 32'd1);
    f0 = first_ev(0, 0);
    chk("pre_w1_burst16", 32'(5 + count_ev(0, f0, 1)), 32'd16);

    // Writer 0 drops after three beats; pointer then favours writer 1.
    do_reset(1);
    seen = '{0, 0}; w_rem[0] = 3; hist.delete();
    run_idle("drop", 20);
    chk("drop_w0_beats", 32'(count_ev(0, hist.size(), 0)), 32'd3);
    w_rem = '{2, 2}; hist.delete();
    run_idle("drop_rr", 50);
    chk("drop_ptr_next", 32'(ev_at(first_ev(0, -1))), 32'd1);

    // Reset lands on what would be beat 7.
    do_reset(1);
    seen = '{0, 0}; w_rem[0] = 20;
    run_seen(0, 6, "rst_mid_six", 40);
    sim_rst = 1'b1; w_rem[0] = 0; hist.delete();
    step();
    sim_rst = 1'b0;
    chk("rst_mid_gnt", 32'(hist[0].gnt), 32'd0);
    chk("rst_mid_we", 32'(hist[0].we), 32'd0);
    seen = '{0, 0}; w_rem = '{16, 16}; hist.delete();
    run_idle("rst_after", 100);
    f1 = first_ev(0, 1);
    chk("rst_after_first", 32'(ev_at(first_ev(0, -1))), 32'd0);
    chk("rst_after_w0_len", 32'(count_ev(0, f1, 0)), 32'd16);

`ifdef FB_ARB_STATS_EN
    // Twenty beats with three single-cycle scan interruptions.
    do_reset(1);
    seen = '{0, 0}; w_rem[0] = 20; pulses = 0; guard = 0;
    while (w_rem[0] > 0 && guard < 100) begin
      if (pulses < 3 && seen[0] == 3 + 5 * pulses) begin
        scan_req = 1'b1;
        step();
        scan_req = 1'b0;
        pulses++;
      end else begin
        step();
      end
      guard++;
    end
    chk("stat_timeout", 32'(w_rem[0]), 32'd0);
    repeat (3) step();
    chk("stat_wr_beats", stat_wr_beats, 32'd20);
    chk("stat_preempts", 32'(stat_preempts), 32'd3);
    chk("stat_maxwait", 32'(stat_maxwait), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 17, framebuffer word address width (320x240 = 76800 words).
REQ-002 SHALL have parameter DATA_W, 8, pixel colour width.
REQ-003 SHALL have parameter BURST_MAX, 16, maximum writer beats per ownership.
REQ-004 SHALL have port clk_pix  in  1  pixel clock, the only clock.
REQ-005 SHALL have port sim_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports scan_req  in  1, scan_addr  in  ADDR_W: scanout read request and address.
REQ-007 SHALL have ports scan_rdata  out  DATA_W, scan_valid  out  1: read data return.
REQ-008 SHALL have ports wr_req  in  2, wr_addr0/wr_addr1  in  ADDR_W, wr_data0/wr_data1  in  DATA_W: game-logic writers 0 and 1.
REQ-009 SHALL have port wr_gnt  out  2: per-writer grant; a beat transfers when wr_req[i] and wr_gnt[i] are both high.
REQ-010 SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W: single-port RAM with 1-cycle read latency.

Function
REQ-011 SHALL be an FSM with states IDLE, OWN0 and OWN1; scanout is never a state and is served combinationally.
REQ-012 SHALL give scan_req absolute priority: in any cycle with scan_req high, mem_en=1, mem_we=0, mem_addr=scan_addr, and wr_gnt=00.
REQ-013 SHALL assert scan_valid exactly 1 cycle after an accepted scan_req, with scan_rdata=mem_rdata in that cycle.
REQ-014 SHALL, in IDLE with scan_req low, grant the requesting writer; if both request, it grants the writer pointed to by a 1-bit round-robin pointer.
REQ-015 SHALL enter OWN<i> when writer i is granted; wr_gnt[i] is combinational in the same cycle, and mem_we=1, mem_addr=wr_addr<i>, mem_wdata=wr_data<i>.
REQ-016 SHALL keep OWN<i> while wr_req[i] stays high and the beat counter is below BURST_MAX; each transferred beat increments the counter.
REQ-017 SHALL, when a scan_req preempts an OWN<i> cycle, hold state and the beat counter unchanged; writer i holds address and data until it is granted.
REQ-018 SHALL leave OWN<i> to IDLE when wr_req[i] drops or the BURST_MAX-th beat transfers, then clear the counter and set the pointer to the other writer.
REQ-019 SHALL, when the other writer is requesting on the exit cycle of REQ-018, grant it on the next cycle without an extra idle cycle.
REQ-020 SHALL never assert both wr_gnt bits at once, and never assert mem_we while scan_req is high.
REQ-021 SHALL drive mem_en=0 and mem_we=0 in any cycle with no scan read and no write beat.

Reset
REQ-022 SHALL, when sim_rst is high at a clk_pix edge, set state=IDLE, pointer=0, beat counter=0 and scan_valid=0; wr_gnt is 00 while sim_rst is high.
REQ-023 SHALL abandon a burst interrupted by reset; no write occurs in the reset cycle.

Configuration
REQ-024 SHALL, with FB_ARB_STATS_EN defined, add outputs stat_wr_beats (32-bit), stat_preempts (16-bit) and stat_maxwait (16-bit); all three clear on sim_rst and saturate, never wrap.
REQ-025 SHALL, without FB_ARB_STATS_EN, omit those ports and their registers; all other behaviour is identical.

Structure
REQ-026 SHALL take the FSM state enum, ADDR_W/DATA_W defaults and frame constants (320, 240) from shared package fb_pkg.
REQ-027 SHALL place the round-robin pointer and the beat counter in sub-module rr_burst_ctr; fb_arbiter holds the FSM and muxing.

Verification
REQ-028 SHALL check: scan_req=1, scan_addr=0x00100 held 4 cycles -> mem_addr=0x00100 with we=0 each cycle, scan_valid high cycles 2-5, wr_gnt=00 throughout.
REQ-029 SHALL check: both writers request from IDLE with pointer=0 -> writer 0 gets 16 beats, then writer 1 is granted on the next cycle.
REQ-030 SHALL check: writer 1 is in beat 5 when scan_req pulses 3 cycles -> wr_gnt=00 for those 3 cycles, writer 1 resumes at beat 6, and its total beat count is 16.
REQ-031 SHALL check: writer 0 drops wr_req after 3 beats -> IDLE the next cycle and pointer=1.
REQ-032 SHALL check: sim_rst asserted mid-burst at beat 7 -> wr_gnt=00 and mem_we=0 in that cycle, state=IDLE and counter=0 after.
REQ-033 SHALL check, with FB_ARB_STATS_EN: 20 beats and 3 preemptions -> stat_wr_beats=20, stat_preempts=3.
